fifo_rr_arbiter: RTL and testbench

- Shares the single enqueue port of a FIFO (ready/valid, WIDTH-bit) among NREQ requesters, e.g. several bus masters feeding the UART TX queue.
- Grants are round-robin and burst-locked: a winner keeps the port for up to MAX_BURST accepted words, or until it drops valid.
- Sits directly in front of the FIFO's enq_valid/enq_data/enq_ready; the FIFO is unchanged.

---
 rtl/rr_priority_pick.sv | 43 ++++
 rtl/fifo_rr_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_rr_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_priority_pick.sv
//------------------------------------------------------------------------------
// rr_priority_pick: picks the first set request after last_ptr, wrapping mod NREQ.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_priority_pick #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);

  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  logic [IW:0]       start;
  logic [IW:0]       pos;
  logic [IW:0]       sum_raw;
  logic [IW:0]       sum_wrap;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;

  // rot[0] is the request just after last_ptr, so a plain lowest-bit encode gives round-robin order
  always_comb begin
    start = {1'b0, last_ptr} + (IW+1)'(1);
    dbl   = {req, req} >> start;
    rot   = dbl[NREQ-1:0];
    pos   = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (rot[i]) pos = (IW+1)'(i);
    end
    sum_raw  = start + pos;
    sum_wrap = (sum_raw >= NREQ_W) ? (sum_raw - NREQ_W) : sum_raw;
    found    = |req;
    idx      = sum_wrap[IW-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/fifo_rr_arbiter.sv
//------------------------------------------------------------------------------
// fifo_rr_arbiter: round-robin, burst-locked sharing of one FIFO enqueue port.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_rr_arbiter #(
  parameter  int WIDTH     = 32,
  parameter  int NREQ      = 4,
  parameter  int MAX_BURST = 4,
  localparam int IW        = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int BW        = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  enq_valid,
  output logic [WIDTH-1:0]      enq_data,
  input  logic                  enq_ready,
  output logic                  grant_valid,
  output logic [IW-1:0]         grant_idx,
  output logic [BW-1:0]         beat_count
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [BW-1:0] LAST_BEAT    = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_PTR_RST = IW'(NREQ - 1);

  state_t           state;
  logic [IW-1:0]    last_ptr;
  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic             xfer;
  logic [WIDTH-1:0] data_arr [NREQ];

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end
  endgenerate

  rr_priority_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req      (req_valid),
    .last_ptr (last_ptr),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // The granted requester is wired straight through, so ready/valid keep zero-cycle coupling
  always_comb begin
    enq_valid   = 1'b0;
    enq_data    = '0;
    req_ready   = '0;
    grant_valid = 1'b0;
    if (state == S_GRANT) begin
      enq_valid            = req_valid[grant_idx];
      enq_data             = data_arr[grant_idx];
      req_ready[grant_idx] = enq_ready;
      grant_valid          = 1'b1;
    end
  end

  assign xfer = enq_valid & enq_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      grant_idx  <= '0;
      last_ptr   <= LAST_PTR_RST;
      beat_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            state      <= S_GRANT;
            grant_idx  <= pick_idx;
            last_ptr   <= pick_idx;
            beat_count <= '0;
          end
        end
        S_GRANT: begin
          if (xfer) begin
            if (beat_count == LAST_BEAT) begin
              state      <= S_IDLE;
              beat_count <= '0;
            end else begin
              beat_count <= beat_count + BW'(1);
            end
          end else if (!req_valid[grant_idx]) begin
            // voluntary release keeps the partial beat count visible while idle
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rr_arbiter.sv
//------------------------------------------------------------------------------
// tb_fifo_rr_arbiter: directed vector tables plus a randomized scoreboard run.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_rr_arbiter;

  localparam logic [31:0] D0 = 32'hA5A5_0000;
  localparam logic [31:0] D1 = 32'h5A5A_1111;
  localparam logic [31:0] D2 = 32'h3C3C_2222;
  localparam logic [31:0] D3 = 32'hC3C3_3333;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [127:0] req_data = {D3, D2, D1, D0};
  logic [3:0]  req_ready;
  logic        enq_valid;
  logic [31:0] enq_data;
  logic        enq_ready = 1'b0;
  logic        grant_valid;
  logic [1:0]  grant_idx;
  logic [2:0]  beat_count;

  logic [2:0]  req_valid3 = '0;
  logic [23:0] req_data3  = '0;
  logic [2:0]  req_ready3;
  logic        enq_valid3;
  logic [7:0]  enq_data3;
  logic        enq_ready3 = 1'b0;
  logic        grant_valid3;
  logic [1:0]  grant_idx3;
  logic [0:0]  beat_count3;

  int n_cmp = 0;
  int n_bad = 0;
  int fifo_cnt = 0;
  int base;

  logic [2:0] hs3 = '0;
  logic [5:0] seq [3];
  logic [5:0] exp_seq [3];

  always #5 clk = ~clk;

  fifo_rr_arbiter #(.WIDTH(32), .NREQ(4), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .beat_count(beat_count)
  );

  fifo_rr_arbiter #(.WIDTH(8), .NREQ(3), .MAX_BURST(1)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_data(req_data3), .req_ready(req_ready3),
    .enq_valid(enq_valid3), .enq_data(enq_data3), .enq_ready(enq_ready3),
    .grant_valid(grant_valid3), .grant_idx(grant_idx3), .beat_count(beat_count3)
  );

  // Words accepted by the FIFO on the main instance
  always @(posedge clk) begin
    if (rst && enq_valid && enq_ready) fifo_cnt <= fifo_cnt + 1;
  end

  typedef struct {
    logic [3:0]  rv;
    logic        er;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  rr;
    logic        gv;
    logic [1:0]  gi;
    logic [2:0]  bc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic [3:0] rv, logic er, logic ev, logic [31:0] ed,
                              logic [3:0] rr, logic gv, logic [1:0] gi, logic [2:0] bc);
    vec_t v;
    v.rv = rv; v.er = er; v.ev = ev; v.ed = ed; v.rr = rr; v.gv = gv; v.gi = gi; v.bc = bc;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [42:0] outs();
    return {enq_valid, enq_data, req_ready, grant_valid, grant_idx, beat_count};
  endfunction

  task automatic step(input logic [3:0] rv, input logic er);
    @(negedge clk);
    req_valid = rv;
    enq_ready = er;
    #1;
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[n]) begin
      step(vecs[n].rv, vecs[n].er);
      check($sformatf("%s[%0d]", tag, n), outs(),
            {vecs[n].ev, vecs[n].ed, vecs[n].rr, vecs[n].gv, vecs[n].gi, vecs[n].bc});
    end
    vecs.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    enq_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic r3_cycle(input bit allow_new);
    logic [1:0] k;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (hs3[i]) begin
        req_valid3[i] = 1'b0;
        seq[i] = seq[i] + 6'd1;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (allow_new && !req_valid3[i] && $urandom_range(0, 2) != 0) begin
        req_valid3[i] = 1'b1;
        req_data3[i*8 +: 8] = {2'(i), seq[i]};
      end
    end
    enq_ready3 = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    hs3 = req_valid3 & req_ready3;
    check("r3_onehot", 64'($countones(req_ready3) <= 1), 64'd1);
    check("r3_push", 64'(enq_valid3 & enq_ready3), 64'(|hs3));
    if (enq_valid3 && enq_ready3) begin
      k = enq_data3[7:6];
      if (k == 2'd3) begin
        check("r3_idx", 64'(k), 64'd2);
      end else begin
        check("r3_word", {hs3[k], enq_data3[5:0]}, {1'b1, exp_seq[k]});
        exp_seq[k] = exp_seq[k] + 6'd1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      seq[i] = '0;
      exp_seq[i] = '0;
    end

    #2;
    check("reset_outs", outs(), 43'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 0 and 2 requesting: two full bursts separated by one bubble, then back to 0
    add(4'b0101, 1, 0, 0, 4'b0000, 0, 0, 0);
    for (int b = 0; b < 4; b++) add(4'b0101, 1, 1, D0, 4'b0001, 1, 0, 3'(b));
    add(4'b0101, 1, 0, 0, 4'b0000, 0, 0, 0);
    for (int b = 0; b < 4; b++) add(4'b0101, 1, 1, D2, 4'b0100, 1, 2, 3'(b));
    add(4'b0101, 1, 0, 0, 4'b0000, 0, 2, 0);
    add(4'b0101, 1, 1, D0, 4'b0001, 1, 0, 0);
    run_vecs("t1_two_req");

    // All four requesting: 0,1,2,3,0 with four beats each
    do_reset();
    for (int g = 0; g < 5; g++) begin
      step(4'hF, 1'b1);
      check($sformatf("t2_bubble%0d", g), 64'(grant_valid), 64'd0);
      for (int b = 0; b < 4; b++) begin
        step(4'hF, 1'b1);
        check($sformatf("t2_g%0d_b%0d", g, b),
              {grant_valid, grant_idx, beat_count, enq_valid, req_ready},
              {1'b1, 2'(g % 4), 3'(b), 1'b1, 4'(1 << (g % 4))});
      end
    end

    // Requester 1 sends two words then releases; requester 3 follows
    do_reset();
    add(4'b0010, 1, 0, 0,  4'b0000, 0, 0, 0);
    add(4'b0010, 1, 1, D1, 4'b0010, 1, 1, 0);
    add(4'b0010, 1, 1, D1, 4'b0010, 1, 1, 1);
    add(4'b1000, 1, 0, D1, 4'b0010, 1, 1, 2);
    add(4'b1000, 1, 0, 0,  4'b0000, 0, 1, 2);
    add(4'b1000, 1, 1, D3, 4'b1000, 1, 3, 0);
    run_vecs("t3_release");

    // FIFO full for ten cycles at beat 1
    do_reset();
    step(4'b0001, 1'b1);
    check("t4_idle", outs(), 43'd0);
    step(4'b0001, 1'b1);
    check("t4_b0", outs(), {1'b1, D0, 4'b0001, 1'b1, 2'd0, 3'd0});
    for (int c = 0; c < 10; c++) begin
      step(4'b0001, 1'b0);
      check($sformatf("t4_full%0d", c), outs(), {1'b1, D0, 4'b0000, 1'b1, 2'd0, 3'd1});
    end
    for (int b = 1; b < 4; b++) begin
      step(4'b0001, 1'b1);
      check($sformatf("t4_resume%0d", b), outs(), {1'b1, D0, 4'b0001, 1'b1, 2'd0, 3'(b)});
    end
    step(4'b0001, 1'b1);
    check("t4_done", outs(), 43'd0);

    // Asynchronous reset at beat 2 of a burst from 0 while 3 is also pending
    do_reset();
    base = fifo_cnt;
    step(4'b1001, 1'b1);
    step(4'b1001, 1'b1);
    step(4'b1001, 1'b1);
    step(4'b1001, 1'b1);
    check("t5_pre", outs(), {1'b1, D0, 4'b0001, 1'b1, 2'd0, 3'd2});
    #2 rst = 1'b0;
    #1;
    check("t5_async", outs(), 43'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_words", 64'(fifo_cnt - base), 64'd2);
    check("t5_idle", outs(), 43'd0);
    step(4'b1001, 1'b1);
    check("t5_regrant", outs(), {1'b1, D0, 4'b0001, 1'b1, 2'd0, 3'd0});

    // Randomized traffic on the 3-requester, single-beat instance
    do_reset();
    hs3 = '0;
    for (int c = 0; c < 10000; c++) r3_cycle(1'b1);
    for (int c = 0; c < 50 && (req_valid3 != 0 || hs3 != 0); c++) r3_cycle(1'b0);
    check("r3_drain", 64'(req_valid3), 64'd0);
    check("r3_count", {seq[0], seq[1], seq[2]}, {exp_seq[0], exp_seq[1], exp_seq[2]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
